// File: rtl/wb_write_queue.sv
// In-order register-write queue between the WB stage and the single regfile write port.
// Define BYPASS_EN to build the q_rn lookup of pending writes; otherwise q_hit/q_d are tied low.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [AW-1:0]            a_wn,
    input  logic [DW-1:0]            a_d,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [AW-1:0]            b_wn,
    input  logic [DW-1:0]            b_d,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wn,
    output logic [DW-1:0]            rf_d,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic [AW-1:0]            q_rn,
    output logic                     q_hit,
    output logic [DW-1:0]            q_d
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] wn_mem [DEPTH];
    logic [DW-1:0] d_mem  [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          rf_we_reg;
    logic [AW-1:0] rf_wn_reg;
    logic [DW-1:0] rf_d_reg;

    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_wn;
    logic [DW-1:0] push_d;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rf_we   = rf_we_reg;
    assign rf_wn   = rf_wn_reg;
    assign rf_d    = rf_d_reg;

    // Ready comes only from registered occupancy and a_valid, never from rf_stall.
    assign a_ready = !full;
    assign b_ready = !full && !a_valid;

    assign push_wn = a_valid ? a_wn : b_wn;
    assign push_d  = a_valid ? a_d  : b_d;
    assign accept  = (a_valid || b_valid) && !full;
    // Writes to r0 are handshaken but dropped.
    assign push    = accept && (push_wn != '0);
    assign pop     = !empty && !rf_stall;

    always_ff @(posedge clk) begin
        if (push) begin
            wn_mem[wr_ptr_reg] <= push_wn;
            d_mem[wr_ptr_reg]  <= push_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rf_we_reg  <= 1'b0;
            rf_wn_reg  <= '0;
            rf_d_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rf_we_reg  <= 1'b1;
                rf_wn_reg  <= wn_mem[rd_ptr_reg];
                rf_d_reg   <= d_mem[rd_ptr_reg];
            end else begin
                rf_we_reg  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef BYPASS_EN
    logic [DEPTH-1:0] ent_match;
    logic [PW-1:0]    scan_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [PW-1:0] age;
            // Distance from the head; only slots closer than count hold live entries.
            assign age            = PW'(gi) - rd_ptr_reg;
            assign ent_match[gi]  = ({1'b0, age} < count_reg) && (wn_mem[gi] == q_rn);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match wins; the rf_* output is oldest.
    always_comb begin
        q_hit    = 1'b0;
        q_d      = '0;
        scan_idx = '0;
        if (q_rn != '0) begin
            if (rf_we_reg && (rf_wn_reg == q_rn)) begin
                q_hit = 1'b1;
                q_d   = rf_d_reg;
            end
            for (int i = 0; i < DEPTH; i++) begin
                scan_idx = rd_ptr_reg + PW'(i);
                if (ent_match[scan_idx]) begin
                    q_hit = 1'b1;
                    q_d   = d_mem[scan_idx];
                end
            end
        end
    end
`else
    logic unused_q_rn;
    assign unused_q_rn = ^q_rn;
    assign q_hit       = 1'b0;
    assign q_d         = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized bench for wb_write_queue against a queue-based model of pending register writes.
// Honours BYPASS_EN the same way as the design.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] wn;
        logic [DW-1:0] d;
    } ent_t;

    logic            clk;
    logic            rst;
    logic            a_valid, b_valid, rf_stall;
    logic            a_ready, b_ready;
    logic [AW-1:0]   a_wn, b_wn, q_rn;
    logic [DW-1:0]   a_d, b_d;
    logic            rf_we;
    logic [AW-1:0]   rf_wn;
    logic [DW-1:0]   rf_d;
    logic [$clog2(DEPTH):0] count;
    logic            full, empty, q_hit;
    logic [DW-1:0]   q_d;

    int checks = 0;
    int errors = 0;

    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_wn;
    logic [DW-1:0] m_d;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_wn(a_wn), .a_d(a_d),
        .b_valid(b_valid), .b_ready(b_ready), .b_wn(b_wn), .b_d(b_d),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
        .count(count), .full(full), .empty(empty),
        .q_rn(q_rn), .q_hit(q_hit), .q_d(q_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the negedge, compare against the model, then advance the model.
    task automatic step(input logic r, input logic av, input logic [AW-1:0] awn, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] bwn, input logic [DW-1:0] bd,
                        input logic st, input logic [AW-1:0] qr);
        logic          e_full;
        logic          e_hit;
        logic [DW-1:0] e_qd;
        logic          acc;
        ent_t          ent;
        rst = r; a_valid = av; a_wn = awn; a_d = ad;
        b_valid = bv; b_wn = bwn; b_d = bd; rf_stall = st; q_rn = qr;
        #1;
        e_full = (mq.size() == DEPTH);
        e_hit  = 1'b0;
        e_qd   = '0;
`ifdef BYPASS_EN
        if (qr != 0) begin
            if (m_we && m_wn == qr) begin e_hit = 1'b1; e_qd = m_d; end
            foreach (mq[i]) if (mq[i].wn == qr) begin e_hit = 1'b1; e_qd = mq[i].d; end
        end
`endif
        check_eq("count",   64'(count),   64'(mq.size()));
        check_eq("full",    64'(full),    64'(e_full));
        check_eq("empty",   64'(empty),   64'(mq.size() == 0));
        check_eq("a_ready", 64'(a_ready), 64'(!e_full));
        check_eq("b_ready", 64'(b_ready), 64'(!e_full && !av));
        check_eq("rf_we",   64'(rf_we),   64'(m_we));
        check_eq("rf_wn",   64'(rf_wn),   64'(m_wn));
        check_eq("rf_d",    64'(rf_d),    64'(m_d));
        check_eq("q_hit",   64'(q_hit),   64'(e_hit));
        check_eq("q_d",     64'(q_d),     64'(e_qd));
        $display("cyc t=%0t rst=%0b A=%0b/%0d B=%0b/%0d stall=%0b -> cnt=%0d we=%0b wn=%0d d=%0h",
                 $time, r, av, awn, bv, bwn, st, count, rf_we, rf_wn, rf_d);
        if (r) begin
            mq.delete();
            m_we = 1'b0; m_wn = '0; m_d = '0;
        end else begin
            acc = (av || bv) && !e_full;
            ent.wn = av ? awn : bwn;
            ent.d  = av ? ad  : bd;
            if (mq.size() > 0 && !st) begin
                m_we = 1'b1; m_wn = mq[0].wn; m_d = mq[0].d;
                void'(mq.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (acc && ent.wn != 0) mq.push_back(ent);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, st, '0);
    endtask

    initial begin
        m_we = 1'b0; m_wn = '0; m_d = '0;
        rst = 1'b1; a_valid = 0; b_valid = 0; rf_stall = 0;
        a_wn = '0; b_wn = '0; a_d = '0; b_d = '0; q_rn = '0;
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 0, '0, '0, 0, '0, '0, 0, '0);

        // Single push, then drain one cycle later.
        step(1'b0, 1, 5'd3, 32'h11, 0, '0, '0, 0, '0);
        check_eq("t2_count", 64'(count), 64'd1);
        idle(1'b0);
        check_eq("t2_we", 64'(rf_we), 64'd1);
        check_eq("t2_wn", 64'(rf_wn), 64'd3);
        check_eq("t2_d",  64'(rf_d),  64'h11);
        check_eq("t2_empty", 64'(empty), 64'd1);
        idle(1'b0);
        check_eq("t2_we_off", 64'(rf_we), 64'd0);

        // A priority over B, B taken the following cycle.
        step(1'b0, 1, 5'd4, 32'hA, 1, 5'd5, 32'hB, 0, '0);
        step(1'b0, 0, '0, '0, 1, 5'd5, 32'hB, 0, '0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        // Fill while stalled; fifth request is refused.
        for (int i = 1; i <= 5; i++) step(1'b0, 1, 5'(i), 32'(i * 16), 0, '0, '0, 1, '0);
        check_eq("t4_full", 64'(full), 64'd1);
        check_eq("t4_a_ready", 64'(a_ready), 64'd0);
        for (int i = 0; i < 6; i++) idle(1'b0);

        // r0 write is dropped; reset flushes stalled entries.
        step(1'b0, 1, 5'd0, 32'hFF, 0, '0, '0, 0, '0);
        check_eq("t5_count", 64'(count), 64'd0);
        for (int i = 1; i <= 3; i++) step(1'b0, 0, '0, '0, 1, 5'(i + 8), 32'(i), 1, '0);
        step(1'b1, 0, '0, '0, 0, '0, '0, 0, '0);
        check_eq("t5_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Bypass: youngest pending r7 wins.
        step(1'b0, 1, 5'd7, 32'h1, 0, '0, '0, 1, '0);
        step(1'b0, 1, 5'd7, 32'h2, 0, '0, '0, 1, '0);
        step(1'b0, 0, '0, '0, 0, '0, '0, 1, 5'd7);
`ifdef BYPASS_EN
        check_eq("t6_hit7", 64'(q_hit), 64'd1);
        check_eq("t6_d7",   64'(q_d),   64'h2);
`else
        check_eq("t6_hit7", 64'(q_hit), 64'd0);
`endif
        step(1'b0, 0, '0, '0, 0, '0, '0, 1, 5'd8);
        step(1'b0, 0, '0, '0, 0, '0, '0, 1, 5'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 0, '0, '0, 0, '0, '0, 0, 5'd7);

        // Random traffic with small register numbers to force collisions and r0 writes.
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
